// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: keeps up to MAX_OUTST in-order fetches in flight and
// buffers the returned words in a FIFO toward decode; a redirect flushes and restarts.
//
// state   | meaning
// S_BOOT  | first cycle after reset release, nothing issued yet
// S_FETCH | issuing sequential fetches while credits allow
// S_FLUSH | waiting for killed responses and any stalled request to drain
module ifu_prefetch #(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = 32'h8000_0000,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter int unsigned      MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] i_addr,
    output logic            i_addr_valid,
    input  logic            i_addr_ready,
    input  logic            i_rdata_valid,
    input  logic [XLEN-1:0] i_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned KW = $clog2(MAX_OUTST + 2);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_addr;
    logic            r_addr_valid;
    logic [OW-1:0]   r_outst;
    logic [KW-1:0]   r_kill;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0] r_tag       [MAX_OUTST];
    logic [TW-1:0]   r_tag_wr;
    logic [TW-1:0]   r_tag_rd;

    logic            w_accept;
    logic            w_rsp;
    logic            w_redirect;
    logic            w_pop;
    logic            w_drop;
    logic            w_push;
    logic            w_hold;
    logic            w_to_fetch;
    logic            w_issue;
    logic [OW-1:0]   w_outst_next;
    logic [CW-1:0]   w_cnt_next;
    logic [KW-1:0]   w_kill_next;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (32'(p) == MAX_OUTST - 1) ? '0 : p + TW'(1);
    endfunction

    assign w_accept   = r_addr_valid & i_addr_ready;
    assign w_rsp      = i_rdata_valid & (r_outst != '0);
    assign w_redirect = redirect_valid & (r_state != S_BOOT);
    assign w_pop      = out_valid & out_ready;
    assign w_drop     = w_rsp & (r_kill != '0);
    assign w_push     = w_rsp & ~w_drop & ~w_redirect;
    assign w_hold     = r_addr_valid & ~i_addr_ready;

    assign w_outst_next = r_outst + OW'(w_accept) - OW'(w_rsp);
    assign w_cnt_next   = w_redirect ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));

    // A stalled request is counted as one more in-flight fetch to kill.
    always_comb begin
        w_kill_next = r_kill;
        if (w_redirect)
            w_kill_next = KW'(w_outst_next) + KW'(w_hold);
        else if (w_drop)
            w_kill_next = r_kill - KW'(1);
    end

    always_comb begin
        w_to_fetch = 1'b0;
        case (r_state)
            S_BOOT:  w_to_fetch = 1'b1;
            S_FETCH: w_to_fetch = ~w_redirect;
            S_FLUSH: w_to_fetch = ~w_redirect & (r_kill == '0) & ~r_addr_valid;
            default: w_to_fetch = 1'b0;
        endcase
    end

    assign w_issue = w_to_fetch
                   & (32'(w_outst_next) < MAX_OUTST)
                   & ((32'(w_outst_next) + 32'(w_cnt_next)) < FIFO_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_fetch_pc   <= RESET_PC;
            r_addr       <= RESET_PC;
            r_addr_valid <= 1'b0;
            r_outst      <= '0;
            r_kill       <= '0;
        end else begin
            case (r_state)
                S_BOOT:  r_state <= S_FETCH;
                S_FETCH: if (w_redirect) r_state <= S_FLUSH;
                S_FLUSH: if (w_to_fetch) r_state <= S_FETCH;
                default: r_state <= S_BOOT;
            endcase
            r_outst <= w_outst_next;
            r_kill  <= w_kill_next;
            if (!w_hold) begin
                r_addr_valid <= w_issue;
                if (w_issue)
                    r_addr <= r_fetch_pc;
            end
            // fetch_pc always names the next address to be presented.
            if (w_redirect)
                r_fetch_pc <= redirect_target;
            else if (!w_hold && w_issue)
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
            end
            for (int i = 0; i < int'(MAX_OUTST); i++)
                r_tag[i] <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
                    r_fifo_inst[r_wr_ptr] <= i_rdata;
                    r_wr_ptr              <= r_wr_ptr + PW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Tags survive a redirect so killed responses still retire in order.
            if (w_accept) begin
                r_tag[r_tag_wr] <= r_addr;
                r_tag_wr        <= tag_inc(r_tag_wr);
            end
            if (w_rsp)
                r_tag_rd <= tag_inc(r_tag_rd);
        end
    end

    assign i_addr       = r_addr;
    assign i_addr_valid = r_addr_valid;
    assign out_valid    = (r_cnt != '0);
    assign out_pc       = out_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign out_inst     = out_valid ? r_fifo_inst[r_rd_ptr] : '0;

`ifndef SYNTHESIS
    a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
        i_rdata_valid |-> (r_outst != '0));
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: random memory/decoder timing and redirects, with outputs
// compared against a sequential-stream reference model by a negedge monitor.
module tb_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 4;
    localparam int          MAXO   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] i_addr;
    logic        i_addr_valid;
    logic        i_addr_ready;
    logic        i_rdata_valid;
    logic [31:0] i_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .i_addr(i_addr), .i_addr_valid(i_addr_valid), .i_addr_ready(i_addr_ready),
        .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // memory and decoder models
    int unsigned ready_pct  = 100;
    int unsigned oready_pct = 100;
    int unsigned lat_min    = 1;
    int unsigned lat_max    = 1;
    int unsigned cyc        = 0;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t mem_q[$];

    initial begin
        i_addr_ready  = 1'b0;
        i_rdata_valid = 1'b0;
        i_rdata       = '0;
        out_ready     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                i_addr_ready  = 1'b0;
                i_rdata_valid = 1'b0;
                out_ready     = 1'b0;
            end else begin
                i_addr_ready = ($urandom_range(99) < ready_pct);
                out_ready    = ($urandom_range(99) < oready_pct);
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    i_rdata_valid = 1'b1;
                    i_rdata       = mem_word(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    i_rdata_valid = 1'b0;
                    i_rdata       = $urandom;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst)
                mem_q.delete();
            else if (i_addr_valid && i_addr_ready)
                mem_q.push_back('{addr: i_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        end
    end

    // reference model + monitor
    logic [31:0] redir_q[$];
    logic [31:0] m_exp_pc, m_req_pc, m_held, m_prev_addr, m_first_pc, m_last_pc, m_prev_opc, m_tgt;
    logic        m_skip, m_prev_stall, m_first_set, m_wrap, m_prev_ohold, m_prev_redir;
    int          m_outst, m_acc, m_hs, m_max_outst;

    initial begin
        m_hs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_exp_pc     = RST_PC;
                m_req_pc     = RST_PC;
                m_skip       = 1'b0;
                m_prev_stall = 1'b0;
                m_prev_ohold = 1'b0;
                m_prev_redir = 1'b0;
                m_first_set  = 1'b0;
                m_outst      = 0;
                m_acc        = 0;
                m_max_outst  = 0;
                m_last_pc    = '0;
            end else begin
                if (m_outst >= MAXO)
                    check("credit_hold", {31'b0, i_addr_valid}, 32'd0);
                if (m_prev_stall) begin
                    check("addr_hold_valid", {31'b0, i_addr_valid}, 32'd1);
                    check("addr_hold", i_addr, m_prev_addr);
                end
                if (m_prev_ohold && !m_prev_redir) begin
                    check("out_hold_valid", {31'b0, out_valid}, 32'd1);
                    check("out_hold_pc", out_pc, m_prev_opc);
                end
                if (i_addr_valid && i_addr_ready) begin
                    if (m_skip) begin
                        check("stale_req_addr", i_addr, m_held);
                        m_skip = 1'b0;
                    end else begin
                        check("req_addr", i_addr, m_req_pc);
                        m_req_pc += 32'd4;
                    end
                    m_acc++;
                end
                if (out_valid && out_ready) begin
                    check("out_pc", out_pc, m_exp_pc);
                    check("out_inst", out_inst, mem_word(m_exp_pc));
                    if (m_last_pc == 32'hFFFF_FFFC && out_pc == 32'h0)
                        m_wrap = 1'b1;
                    m_last_pc = out_pc;
                    if (!m_first_set) begin
                        m_first_pc  = out_pc;
                        m_first_set = 1'b1;
                    end
                    m_exp_pc += 32'd4;
                    m_hs++;
                end
                if (redirect_valid) begin
                    m_tgt = (redir_q.size() > 0) ? redir_q.pop_front() : redirect_target;
                    m_exp_pc    = m_tgt;
                    m_req_pc    = m_tgt;
                    m_first_set = 1'b0;
                    if (i_addr_valid && !i_addr_ready) begin
                        m_skip = 1'b1;
                        m_held = i_addr;
                    end
                end
                m_outst = m_outst + int'(i_addr_valid && i_addr_ready) - int'(i_rdata_valid);
                if (m_outst > m_max_outst)
                    m_max_outst = m_outst;
                check("outst_bound", {31'b0, (m_outst <= MAXO)}, 32'd1);
                m_prev_stall = i_addr_valid && !i_addr_ready;
                m_prev_addr  = i_addr;
                m_prev_ohold = out_valid && !out_ready;
                m_prev_opc   = out_pc;
                m_prev_redir = redirect_valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_i_addr", i_addr, RST_PC);
        check("rst_i_addr_valid", {31'b0, i_addr_valid}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("boot_first_valid", {31'b0, i_addr_valid}, 32'd1);
        check("boot_first_addr", i_addr, RST_PC);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redir_q.push_back(t);
        redirect_target = t;
        redirect_valid  = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got %0d tests", n_tests);
        $fatal(1);
    end

    initial begin
        int hs0;
        int w;
        logic [31:0] old_addr;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        m_wrap          = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        release_reset();

        // sequential stream with single-cycle memory
        hs0 = m_hs;
        tick(30);
        check("p1_throughput", {31'b0, (m_hs - hs0 >= 20)}, 32'd1);

        // decoder stalled: exactly FIFO_DEPTH requests accepted
        oready_pct = 0;
        do_reset();
        tick(30);
        check("p2_accepts", m_acc, DEPTH);
        check("p2_i_addr_valid", {31'b0, i_addr_valid}, 32'd0);
        check("p2_out_valid", {31'b0, out_valid}, 32'd1);
        check("p2_out_pc", out_pc, RST_PC);
        oready_pct = 100;
        tick(20);

        // long latency: outstanding bound
        lat_min = 5;
        lat_max = 5;
        tick(80);
        check("p3_max_outst", m_max_outst, MAXO);

        // redirect with requests in flight and FIFO occupied
        oready_pct = 0;
        tick(2);
        w = 0;
        while (!(out_valid && m_outst == MAXO) && w < 60) begin
            tick(1);
            w++;
        end
        check("p4_setup", {31'b0, (out_valid && m_outst == MAXO)}, 32'd1);
        do_redirect(32'h8000_0100);
        check("p4_fifo_flushed", {31'b0, out_valid}, 32'd0);
        oready_pct = 100;
        tick(40);
        check("p4_first_set", {31'b0, m_first_set}, 32'd1);
        check("p4_first_pc", m_first_pc, 32'h8000_0100);

        // redirect while a request is stalled
        ready_pct = 0;
        tick(3);
        w = 0;
        while (!i_addr_valid && w < 60) begin
            tick(1);
            w++;
        end
        check("p5_setup", {31'b0, i_addr_valid}, 32'd1);
        old_addr = i_addr;
        do_redirect(32'h8000_0200);
        tick(3);
        check("p5_hold_valid", {31'b0, i_addr_valid}, 32'd1);
        check("p5_hold_addr", i_addr, old_addr);
        ready_pct = 100;
        tick(40);
        check("p5_first_pc", m_first_pc, 32'h8000_0200);

        // back-to-back redirects, last one wins
        lat_min = 3;
        lat_max = 3;
        tick(5);
        do_redirect(32'h0000_0100);
        do_redirect(32'h0000_0200);
        tick(40);
        check("p6_first_pc", m_first_pc, 32'h0000_0200);

        // address wrap
        lat_min = 1;
        lat_max = 1;
        tick(3);
        do_redirect(32'hFFFF_FFF0);
        tick(30);
        check("p7_wrap", {31'b0, m_wrap}, 32'd1);

        // randomized traffic
        hs0 = m_hs;
        for (int blk = 0; blk < 15; blk++) begin
            ready_pct  = $urandom_range(100, 30);
            oready_pct = $urandom_range(100, 20);
            lat_min    = 1;
            lat_max    = $urandom_range(6, 1);
            if (blk == 7) begin
                do_reset();
                hs0 = m_hs;
            end
            for (int c = 0; c < 200; c++) begin
                tick(1);
                if ($urandom_range(99) < 3)
                    do_redirect($urandom & 32'hFFFF_FFFC);
            end
        end
        check("p8_progress", {31'b0, (m_hs - hs0 > 200)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
